// File: rtl/bram_stream_dma.sv
// bram_stream_dma: sequential load/dump engine driving one port of a true_dpbram buffer.
// Load mode copies a valid/ready input stream into consecutive BRAM words.
// Dump mode reads consecutive BRAM words out to a valid/ready stream. A 2-entry FIFO
// absorbs the one-cycle BRAM read latency so the stream can run at one word per clock
// and still tolerate arbitrary backpressure.
module bram_stream_dma #(
    parameter int DWIDTH   = 112,
    parameter int AWIDTH   = 13,
    parameter int MEM_SIZE = 4116,
    parameter int LWIDTH   = AWIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [LWIDTH-1:0] len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DWIDTH-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_last_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_d_o,
    input  logic [DWIDTH-1:0] mem_q_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The range check runs one bit wider than the length field so base+len cannot wrap.
    localparam logic [LWIDTH:0]   MEM_SIZE_C = (LWIDTH+1)'(MEM_SIZE);
    localparam logic [LWIDTH-1:0] LEN_ONE_C  = {{(LWIDTH-1){1'b0}}, 1'b1};
    localparam logic [LWIDTH-1:0] LEN_ZERO_C = {LWIDTH{1'b0}};

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   base_q, base_d;
    logic [LWIDTH-1:0]   len_q, len_d;
    logic [LWIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LWIDTH-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LWIDTH-1:0]   pop_cnt_q, pop_cnt_d;
    logic                err_q, err_d;
    logic                inflight_q, inflight_d;
    logic [DWIDTH-1:0]   fifo_q [2];
    logic [DWIDTH-1:0]   fifo_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          occ_q, occ_d;

    logic [LWIDTH:0]     end_addr_s;
    logic                start_bad_s;
    logic [LWIDTH-1:0]   last_idx_s;
    logic                s_ready_s;
    logic                load_fire_s;
    logic                fifo_nonempty_s;
    logic                pop_s;
    logic [2:0]          fill_level_s;
    logic                rd_issue_s;
    logic [DWIDTH-1:0]   fifo_head_s;

    assign end_addr_s      = (LWIDTH+1)'(base_addr_i) + (LWIDTH+1)'(len_i);
    assign start_bad_s     = (len_i == LEN_ZERO_C) || (end_addr_s > MEM_SIZE_C);
    assign last_idx_s      = len_q - LEN_ONE_C;
    assign s_ready_s       = (state_q == ST_LOAD) && (wr_cnt_q < len_q);
    assign load_fire_s     = s_valid_i && s_ready_s;
    assign fifo_nonempty_s = (occ_q != 2'd0);
    assign pop_s           = fifo_nonempty_s && m_ready_i;
    assign fifo_head_s     = fifo_q[rd_ptr_q];
    // Words already buffered plus the one still coming back from the BRAM.
    assign fill_level_s    = {1'b0, occ_q} + {2'b00, inflight_q};
    // A read may issue only if its data is guaranteed a FIFO slot when it returns.
    assign rd_issue_s      = (state_q == ST_DUMP) && (rd_cnt_q < len_q) &&
                             (fill_level_s < (3'd2 + {2'b00, pop_s}));

    // Drive status, stream and BRAM port outputs from the current state and handshakes.
    always_comb begin
        busy_o     = (state_q != ST_IDLE);
        done_o     = (state_q == ST_DONE);
        err_o      = err_q;
        s_ready_o  = s_ready_s;
        m_valid_o  = fifo_nonempty_s;
        m_data_o   = {DWIDTH{1'b0}};
        m_last_o   = 1'b0;
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = {AWIDTH{1'b0}};
        mem_d_o    = {DWIDTH{1'b0}};
        if (fifo_nonempty_s) begin
            m_data_o = fifo_head_s;
            m_last_o = (pop_cnt_q == last_idx_s);
        end else begin
            m_data_o = {DWIDTH{1'b0}};
            m_last_o = 1'b0;
        end
        if (load_fire_s) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = base_q + wr_cnt_q[AWIDTH-1:0];
            mem_d_o    = s_data_i;
        end else if (rd_issue_s) begin
            mem_ce_o   = 1'b1;
            mem_we_o   = 1'b0;
            mem_addr_o = base_q + rd_cnt_q[AWIDTH-1:0];
        end else begin
            mem_ce_o   = 1'b0;
        end
    end

    // Command sequencing: start check, per-mode counters and completion detection.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        err_d      = err_q;
        inflight_d = rd_issue_s;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_bad_s) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d     = 1'b0;
                        base_d    = base_addr_i;
                        len_d     = len_i;
                        wr_cnt_d  = LEN_ZERO_C;
                        rd_cnt_d  = LEN_ZERO_C;
                        pop_cnt_d = LEN_ZERO_C;
                        state_d   = mode_i ? ST_DUMP : ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_fire_s) begin
                    wr_cnt_d = wr_cnt_q + LEN_ONE_C;
                    if (wr_cnt_q == last_idx_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DUMP: begin
                if (rd_issue_s) begin
                    rd_cnt_d = rd_cnt_q + LEN_ONE_C;
                end else begin
                    rd_cnt_d = rd_cnt_q;
                end
                if (pop_s) begin
                    pop_cnt_d = pop_cnt_q + LEN_ONE_C;
                    if (pop_cnt_q == last_idx_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DUMP;
                    end
                end else begin
                    state_d = ST_DUMP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: push returning read data, pop on stream handshake, both in one cycle.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = mem_q_i;
            wr_ptr_d         = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
    end

    // State register; reset abandons any command and discards a read still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= {AWIDTH{1'b0}};
            len_q      <= LEN_ZERO_C;
            wr_cnt_q   <= LEN_ZERO_C;
            rd_cnt_q   <= LEN_ZERO_C;
            pop_cnt_q  <= LEN_ZERO_C;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            fifo_q     <= '{default: {DWIDTH{1'b0}}};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: doc/bram_stream_dma.md
Name: bram_stream_dma

Overview:
- Synthesizable port-1 engine for one true_dpbram instance (ifmap, weight or ofmap buffer).
- Load mode: writes a valid/ready input stream into sequential BRAM addresses.
- Dump mode: reads sequential BRAM addresses into a valid/ready output stream, with backpressure and last-beat marking.
- Replaces bench-only preload/readback loops; one instance per buffer, width/depth set per instance (112b x 4116 ifmap, 112b x 1470 weight, 112b x 896 ofmap).

Parameters:
- DWIDTH, 112, BRAM word width (PE_SIZE x DATA_WIDTH).
- AWIDTH, 13, BRAM address width.
- MEM_SIZE, 4116, BRAM depth in words; legal addresses 0..MEM_SIZE-1.
- LWIDTH, AWIDTH+1, width of transfer length field.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  command strobe, sampled only in IDLE
- mode_i  in  1  0 = load (stream->BRAM), 1 = dump (BRAM->stream); sampled with start_i
- base_addr_i  in  AWIDTH  first BRAM address; sampled with start_i
- len_i  in  LWIDTH  number of words; sampled with start_i
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at end of command (success or error)
- err_o  out  1  command rejected; held until next accepted start_i
- s_valid_i  in  1  load stream valid
- s_ready_o  out  1  load stream ready
- s_data_i  in  DWIDTH  load stream data
- m_valid_o  out  1  dump stream valid
- m_ready_i  in  1  dump stream ready
- m_data_o  out  DWIDTH  dump stream data
- m_last_o  out  1  high with final dump word
- mem_ce_o  out  1  BRAM port chip enable
- mem_we_o  out  1  BRAM port write enable
- mem_addr_o  out  AWIDTH  BRAM port address
- mem_d_o  out  DWIDTH  BRAM write data
- mem_q_i  in  DWIDTH  BRAM read data, valid in the cycle after the ce=1, we=0 edge

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; counters, 2-entry output FIFO and in-flight flag cleared.
- All outputs reset to 0: busy_o, done_o, err_o, s_ready_o, m_valid_o, m_data_o, m_last_o, mem_ce_o, mem_we_o, mem_addr_o, mem_d_o.
- Reset mid-command aborts it: no done_o, any in-flight read is discarded.
- States and transitions:
  - IDLE -> LOAD/DUMP/DONE when start_i is sampled.
  - LOAD/DUMP -> DONE when complete.
  - DONE -> IDLE after one cycle.
- Start check, at the sampling edge: if len_i==0 or base_addr_i+len_i > MEM_SIZE (computed at LWIDTH+1 bits, no wrap), go to DONE with err_o set.
  - In that case no BRAM access is made.
  - Otherwise latch mode, base and len, clear err_o, zero counters.
- start_i outside IDLE is ignored. done_o is high only while in DONE.
- LOAD:
  - s_ready_o = 1 while wr_cnt < len.
  - On s_valid_i & s_ready_o (same cycle, combinational): mem_ce_o=1, mem_we_o=1, mem_addr_o=base+wr_cnt, mem_d_o=s_data_i; wr_cnt increments at the edge.
  - After the write with wr_cnt==len-1, go to DONE; s_ready_o=0 from then on.
  - Input stalls (s_valid_i=0) insert idle cycles with mem_ce_o=0.
- DUMP:
  - mem_we_o is always 0.
  - A read issues (mem_ce_o=1, mem_addr_o=base+rd_cnt) when rd_cnt < len and fifo_occ + inflight - pop < 2, where pop = m_valid_o & m_ready_i.
  - inflight is set for exactly the cycle after an issue; mem_q_i is pushed into the FIFO in that cycle.
  - m_valid_o = FIFO non-empty; m_data_o = FIFO head.
  - m_last_o = 1 when the head is word len-1.
  - Command ends when the last word pops; go to DONE.
- Dump timing: start sampled in cycle 0, first read in cycle 1, first m_valid_o in cycle 3.
  - With m_ready_i held 1, throughput is one word per clock.
  - done_o occurs in the cycle after the last pop.
- No data loss or duplication under arbitrary m_ready_i; the FIFO never exceeds 2 entries.
- Push and pop in the same cycle are both honoured.
- Address arithmetic is AWIDTH bits; the range check guarantees no wrap past MEM_SIZE-1.

Test Plan:
- Load base=10 len=4, words 0xA..0xD, s_valid_i always 1 -> writes at addr 10..13 in 4 consecutive cycles, done_o in cycle 5; dump base=10 len=4 with m_ready_i=1 -> 0xA..0xD on consecutive cycles, m_last_o on 0xD.
- Dump len=6 with m_ready_i toggling 1,0,0,1,... -> all 6 words exactly once and in order, m_valid_o never drops while unpopped, never more than 2 reads outstanding past unpopped data.
- len=0, then base=4110 len=7 (MEM_SIZE=4116) -> no mem_ce_o, done_o and err_o next cycle; err_o stays high until a valid start is accepted, then clears.
- Full-depth load base=0 len=4116 with random s_valid_i gaps, then dump -> address 4115 written and read back, no address wrap, data matches.
- rst_n=0 for one edge during a dump after word 2 -> all outputs 0 next cycle, no done_o; a new dump then returns correct data from base.
- start_i pulsed during an active load -> ignored; the original command completes with a single done_o.
